// File: rtl/otp_key_stream_if.sv
// Key stream link between the one-time-pad key source and its consumer.
// The master side is the key generator; the slave side is the consumer
// (e.g. the brickwall encryptor/decryptor) which also supplies the seed.
interface otp_key_stream_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 11
);
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             key_ready;
    logic             key_valid;
    logic [WIDTH-1:0] key;
    logic [CW-1:0]    key_index;
    logic             exhausted;
    logic             zero_seed;

    modport master (
        input  seed_load,
        input  seed,
        input  key_ready,
        output key_valid,
        output key,
        output key_index,
        output exhausted,
        output zero_seed
    );

    modport slave (
        output seed_load,
        output seed,
        output key_ready,
        input  key_valid,
        input  key,
        input  key_index,
        input  exhausted,
        input  zero_seed
    );
endinterface

// File: rtl/otp_key_stream.sv
// One-time-pad key stream generator.
// A Galois LFSR seeded by seed_load is advanced STEPS times per key (unrolled
// into a single cycle), warmed up for WARMUP advances, and then presents one
// key per accepted handshake until MAX_KEYS keys have been issued. After that
// the stream stays exhausted until it is reseeded, so no pad word is reused.
// The CW parameter must match the CW of the connected interface.
module otp_key_stream #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] POLY     = 32'h80200003,
    parameter int               STEPS    = 32,
    parameter int               WARMUP   = 16,
    parameter int               MAX_KEYS = 1024,
    parameter int               CW       = $clog2(MAX_KEYS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    otp_key_stream_if.master   bus
);

    // Warm-up counter is sized so that WARMUP=0 still yields a legal width.
    localparam int             WW         = $clog2(WARMUP + 2);
    localparam logic [WW-1:0]  WARM_LAST  = WW'((WARMUP > 0) ? (WARMUP - 1) : 0);
    localparam logic [CW-1:0]  IDX_LAST   = CW'(MAX_KEYS - 1);
    localparam logic [WIDTH-1:0] LFSR_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        EXH  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [CW-1:0]    idx_q;
    logic [CW-1:0]    idx_d;
    logic [WW-1:0]    warm_q;
    logic [WW-1:0]    warm_d;
    logic             zero_q;
    logic             zero_d;
    logic             valid_q;
    logic             exh_q;
    logic [WIDTH-1:0] lfsr_adv;

    // One advance = STEPS Galois shifts. Since the register is never zero and
    // the feedback polynomial is primitive, the state can never collapse to 0.
    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
        for (int i = 0; i < STEPS; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign lfsr_adv = adv(lfsr_q);

    // State register; reset drops any stream in progress back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath decisions; a seed load overrides everything,
    // including a handshake that happens to coincide with it.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        warm_d  = warm_q;
        zero_d  = 1'b0;

        if (bus.seed_load) begin
            lfsr_d  = (bus.seed == '0) ? LFSR_ONE : bus.seed;
            zero_d  = (bus.seed == '0);
            idx_d   = '0;
            warm_d  = '0;
            state_d = (WARMUP > 0) ? WARM : RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                WARM: begin
                    lfsr_d = lfsr_adv;
                    if (warm_q == WARM_LAST) begin
                        state_d = RUN;
                    end else begin
                        warm_d = warm_q + WW'(1);
                    end
                end
                RUN: begin
                    if (valid_q && bus.key_ready) begin
                        lfsr_d = lfsr_adv;
                        idx_d  = idx_q + CW'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = EXH;
                        end
                    end
                end
                EXH: begin
                    state_d = EXH;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Datapath and registered status flags, derived from the next state so
    // key_valid and exhausted line up exactly with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= LFSR_ONE;
            idx_q   <= '0;
            warm_q  <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            warm_q  <= warm_d;
            zero_q  <= zero_d;
            valid_q <= (state_d == RUN);
            exh_q   <= (state_d == EXH);
        end
    end

    assign bus.key       = lfsr_q;
    assign bus.key_index = idx_q;
    assign bus.key_valid = valid_q;
    assign bus.exhausted = exh_q;
    assign bus.zero_seed = zero_q;

endmodule

// File: tb/tb_otp_key_stream.sv
// Testbench for otp_key_stream: a short-pad instance (STEPS=1, WARMUP=0,
// MAX_KEYS=4) checked from a vector table, and a default instance checked
// under random backpressure against a behavioural key stream model.
module tb_otp_key_stream;

    localparam logic [31:0] POLY = 32'h80200003;
    localparam int A_STEPS  = 32;
    localparam int A_WARMUP = 16;
    localparam int A_MAX    = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    otp_key_stream_if #(.WIDTH(32), .CW(11)) ifa ();
    otp_key_stream_if #(.WIDTH(32), .CW(3))  ifb ();

    otp_key_stream dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.master)
    );

    otp_key_stream #(
        .STEPS    (1),
        .WARMUP   (0),
        .MAX_KEYS (4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.master)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model of the default instance.
    logic [31:0] mkey;
    int          midx;
    bit          mexh;

    typedef struct {
        logic        load;
        logic [31:0] seed;
        logic        ready;
        logic        exp_valid;
        logic        chk_key;
        logic [31:0] exp_key;
        logic [2:0]  exp_idx;
        logic        exp_exh;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [10];

    // Reference LFSR advance written from the shift/xor rule with arithmetic.
    function automatic logic [31:0] ref_adv(input logic [31:0] s, input int steps);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < steps; i++) begin
            if ((r % 2) == 1) r = (r / 2) ^ POLY;
            else              r = r / 2;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one interface (0 = default instance, 1 = short-pad instance).
    task automatic applyStimulus(input int sel, input logic load, input logic [31:0] seed,
                                 input logic ready);
        if (sel == 0) begin
            ifa.seed_load = load;
            ifa.seed      = seed;
            ifa.key_ready = ready;
        end else begin
            ifb.seed_load = load;
            ifb.seed      = seed;
            ifb.key_ready = ready;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reseed the default instance and wait for its first key, checking the
    // warm-up latency and the first key against the model.
    task automatic load_and_warm(input logic [31:0] seed, input logic ready_at_load);
        int edges;
        applyStimulus(0, 1'b1, seed, ready_at_load);
        tick();
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        mkey = (seed == 32'h0) ? 32'h1 : seed;
        for (int i = 0; i < A_WARMUP; i++) mkey = ref_adv(mkey, A_STEPS);
        midx = 0;
        mexh = 1'b0;
        checkOutput("zero_seed_pulse", 64'(ifa.zero_seed), 64'(seed == 32'h0));
        checkOutput("exhausted_cleared", 64'(ifa.exhausted), 64'd0);
        edges = 1;
        while (!ifa.key_valid && edges < 40) begin
            tick();
            edges++;
            if (edges == 2) checkOutput("zero_seed_one_cycle", 64'(ifa.zero_seed), 64'd0);
        end
        checkOutput("warmup_latency", 64'(edges), 64'(A_WARMUP + 1));
        checkOutput("first_key", 64'(ifa.key), 64'(mkey));
        checkOutput("first_index", 64'(ifa.key_index), 64'd0);
    endtask

    // Random-ready traffic on the default instance compared with the model.
    task automatic run_random(input int cycles, input int ready_pct);
        logic r;
        for (int i = 0; i < cycles; i++) begin
            r = ($urandom_range(99) < ready_pct);
            applyStimulus(0, 1'b0, 32'h0, r);
            tick();
            if (!mexh && r) begin
                mkey = ref_adv(mkey, A_STEPS);
                midx++;
                if (midx == A_MAX) mexh = 1'b1;
            end
            checkOutput("a_valid", 64'(ifa.key_valid), 64'(!mexh));
            checkOutput("a_exhausted", 64'(ifa.exhausted), 64'(mexh));
            if (!mexh) begin
                checkOutput("a_key", 64'(ifa.key), 64'(mkey));
                checkOutput("a_index", 64'(ifa.key_index), 64'(midx));
            end
        end
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        // Short-pad instance: seed 1 stream, exhaustion, zero seed, reload-wins.
        vecs[0] = '{1'b1, 32'h1, 1'b0, 1'b1, 1'b1, 32'h00000001, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80200003, 3'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC0300002, 3'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h60180001, 3'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h00000001, 3'd0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00000001, 3'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80200003, 3'd1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h00000001, 3'd0, 1'b0, 1'b0};

        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        checkOutput("rst_a_valid", 64'(ifa.key_valid), 64'd0);
        checkOutput("rst_a_key", 64'(ifa.key), 64'd1);
        checkOutput("rst_a_index", 64'(ifa.key_index), 64'd0);
        checkOutput("rst_a_exhausted", 64'(ifa.exhausted), 64'd0);
        checkOutput("rst_a_zero", 64'(ifa.zero_seed), 64'd0);
        checkOutput("rst_b_valid", 64'(ifb.key_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_a_valid", 64'(ifa.key_valid), 64'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, vecs[i].load, vecs[i].seed, vecs[i].ready);
            tick();
            checkOutput($sformatf("b_valid[%0d]", i), 64'(ifb.key_valid), 64'(vecs[i].exp_valid));
            checkOutput($sformatf("b_exh[%0d]", i), 64'(ifb.exhausted), 64'(vecs[i].exp_exh));
            checkOutput($sformatf("b_zero[%0d]", i), 64'(ifb.zero_seed), 64'(vecs[i].exp_zero));
            if (vecs[i].chk_key) begin
                checkOutput($sformatf("b_key[%0d]", i), 64'(ifb.key), 64'(vecs[i].exp_key));
                checkOutput($sformatf("b_index[%0d]", i), 64'(ifb.key_index), 64'(vecs[i].exp_idx));
            end
        end
        applyStimulus(1, 1'b0, 32'h0, 1'b0);

        // Default instance: random seed, random ready, then explicit backpressure.
        load_and_warm($urandom(), 1'b1);
        run_random(80, 60);
        run_random(5, 0);
        run_random(1, 100);

        // Reload while a handshake is live: reload must win.
        load_and_warm($urandom(), 1'b1);
        run_random(20, 100);

        // Zero seed behaves like seed 1.
        load_and_warm(32'h0, 1'b0);
        run_random(40, 100);

        // Asynchronous reset mid-run, observed before the next clock edge.
        rst_n = 1'b0;
        #2;
        checkOutput("async_rst_valid", 64'(ifa.key_valid), 64'd0);
        checkOutput("async_rst_index", 64'(ifa.key_index), 64'd0);
        checkOutput("async_rst_exh", 64'(ifa.exhausted), 64'd0);
        checkOutput("async_rst_key", 64'(ifa.key), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Run a full pad to exhaustion, then confirm ready is ignored and reseed restarts.
        load_and_warm($urandom(), 1'b0);
        run_random(A_MAX + 20, 90);
        if (!mexh) run_random(A_MAX, 100);
        checkOutput("a_reached_exhaustion", 64'(ifa.exhausted), 64'd1);
        run_random(10, 100);
        load_and_warm($urandom(), 1'b0);
        run_random(10, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
